ttt_game_ctrl: RTL and testbench

//  Game-sequencing controller for the tic-tac-toe board: takes one-cycle key events from the keypad scanner, manages

---
 rtl/ttt_game_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_ttt_game_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game sequencer.
// Turns one-cycle keypad events into moves. It tracks the main/game mode, whose turn it is,
// whether a cell is free, the move count and three-in-a-row detection. It owns the board
// register that the display blocks read.
//
// Ports:
//   clk, rst   system clock; asynchronous active-high reset
//   game_en    level: 1 = game mode, 0 = main (title) screen
//   key_valid  one-cycle strobe qualifying key_code
//   key_code   1..9 = cell, 10 = '*' restart, other codes are ignored
//   board      cell k (1..9) at [19-2k:18-2k]; upper bit = O stone, lower bit = X stone
//   turn_o     0 = X to move, 1 = O to move
//   result     00 playing, 01 X wins, 10 O wins, 11 draw
//   in_main    high while on the main screen
//   illegal    one-cycle pulse, held during PLACE, when the pressed cell is occupied
//   state_o    current FSM state (debug)
module ttt_game_ctrl #(
  parameter int unsigned HOLD_CYCLES = 25000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_en,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [17:0] board,
  output logic        turn_o,
  output logic [1:0]  result,
  output logic        in_main,
  output logic        illegal,
  output logic [2:0]  state_o
);

  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    StMain  = 3'd0,
    StWait  = 3'd1,
    StPlace = 3'd2,
    StCheck = 3'd3,
    StOver  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [8:0]       xs_q, xs_d;      // X stones, bit k-1 = cell k
  logic [8:0]       os_q, os_d;      // O stones
  logic [8:0]       cell_q, cell_d;  // one-hot cell latched in WAIT
  logic             turn_q, turn_d;
  logic [1:0]       result_q, result_d;
  logic             illegal_q, illegal_d;
  logic             in_main_q, in_main_d;
  logic [3:0]       move_cnt_q, move_cnt_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;

  logic [8:0] key_oh;
  logic [8:0] mv;
  logic       key_is_cell, key_is_star, hold_sat, mover_wins, leave_game;

  always_comb begin
    key_oh = '0;
    for (int i = 0; i < 9; i++) begin
      if (key_code == 4'(i + 1)) key_oh[i] = 1'b1;
    end
  end

  assign key_is_cell = |key_oh;
  assign key_is_star = (key_code == 4'd10);
  assign hold_sat    = (hold_cnt_q == HoldMax);
  assign leave_game  = (state_q != StMain) && !game_en;

  // Only the player who just moved can have completed a line.
  assign mv = turn_q ? os_q : xs_q;
  assign mover_wins = (&mv[2:0]) | (&mv[5:3]) | (&mv[8:6]) |
                      (mv[0] & mv[3] & mv[6]) | (mv[1] & mv[4] & mv[7]) |
                      (mv[2] & mv[5] & mv[8]) |
                      (mv[0] & mv[4] & mv[8]) | (mv[2] & mv[4] & mv[6]);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StMain;
    else     state_q <= state_d;
  end

  // Next-state logic; dropping game_en overrides everything, including a key.
  always_comb begin
    state_d = state_q;
    if (leave_game) begin
      state_d = StMain;
    end else begin
      unique case (state_q)
        StMain:  if (game_en) state_d = StWait;
        StWait:  if (key_valid && key_is_cell) state_d = StPlace;
        StPlace: state_d = illegal_q ? StWait : StCheck;
        StCheck: state_d = (mover_wins || move_cnt_q == 4'd9) ? StOver : StWait;
        StOver:  if (hold_sat && key_valid) state_d = StWait;
        default: state_d = StMain;
      endcase
    end
  end

  // Datapath / registered-output next values
  always_comb begin
    xs_d       = xs_q;
    os_d       = os_q;
    cell_d     = cell_q;
    turn_d     = turn_q;
    result_d   = result_q;
    move_cnt_d = move_cnt_q;
    hold_cnt_d = hold_cnt_q;
    illegal_d  = 1'b0;
    in_main_d  = (state_d == StMain);

    if (leave_game || state_q == StMain || !(state_q inside {StWait, StPlace, StCheck, StOver}))
    begin
      // Leaving a game, idling on the title screen or recovering from a bad code: fresh game.
      xs_d       = '0;
      os_d       = '0;
      turn_d     = 1'b0;
      result_d   = 2'b00;
      move_cnt_d = '0;
      hold_cnt_d = '0;
    end else begin
      unique case (state_q)
        StWait: begin
          if (key_valid && key_is_cell) begin
            cell_d = key_oh;
            // Decided here so the flag is a register already high during PLACE.
            illegal_d = |(key_oh & (xs_q | os_q));
          end else if (key_valid && key_is_star) begin
            xs_d       = '0;
            os_d       = '0;
            turn_d     = 1'b0;
            move_cnt_d = '0;
          end
        end
        StPlace: begin
          if (!illegal_q) begin
            if (turn_q) os_d = os_q | cell_q;
            else        xs_d = xs_q | cell_q;
            move_cnt_d = move_cnt_q + 4'd1;
          end
        end
        StCheck: begin
          hold_cnt_d = '0;
          if (mover_wins)                result_d = turn_q ? 2'b10 : 2'b01;
          else if (move_cnt_q == 4'd9)   result_d = 2'b11;
          else                           turn_d   = ~turn_q;
        end
        StOver: begin
          if (hold_sat) begin
            if (key_valid) begin
              xs_d       = '0;
              os_d       = '0;
              turn_d     = 1'b0;
              result_d   = 2'b00;
              move_cnt_d = '0;
              hold_cnt_d = '0;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xs_q       <= '0;
      os_q       <= '0;
      cell_q     <= '0;
      turn_q     <= 1'b0;
      result_q   <= 2'b00;
      illegal_q  <= 1'b0;
      in_main_q  <= 1'b1;
      move_cnt_q <= '0;
      hold_cnt_q <= '0;
    end else begin
      xs_q       <= xs_d;
      os_q       <= os_d;
      cell_q     <= cell_d;
      turn_q     <= turn_d;
      result_q   <= result_d;
      illegal_q  <= illegal_d;
      in_main_q  <= in_main_d;
      move_cnt_q <= move_cnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Board layout: pure rewiring of the stone registers.
  always_comb begin
    board = '0;
    for (int k = 0; k < 9; k++) begin
      board[17 - 2 * k] = os_q[k];
      board[16 - 2 * k] = xs_q[k];
    end
  end

  assign turn_o  = turn_q;
  assign result  = result_q;
  assign in_main = in_main_q;
  assign illegal = illegal_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Self-checking bench for ttt_game_ctrl: a game-level model is compared with the DUT on every
// cycle, and hand-computed literals are checked at the key points of each scenario.
module tb_ttt_game_ctrl;

  localparam int unsigned Hold = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        game_en;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [17:0] board;
  logic        turn_o;
  logic [1:0]  result;
  logic        in_main;
  logic        illegal;
  logic [2:0]  state_o;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  ttt_game_ctrl #(.HOLD_CYCLES(Hold)) dut (
    .clk      (clk),
    .rst      (rst),
    .game_en  (game_en),
    .key_valid(key_valid),
    .key_code (key_code),
    .board    (board),
    .turn_o   (turn_o),
    .result   (result),
    .in_main  (in_main),
    .illegal  (illegal),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  // ---------------- game-level model ----------------
  // cells[i] holds cell i+1: 0 empty, 1 X, 2 O. ph is the phase of the game, 0..4.
  typedef struct packed {
    logic [2:0]       ph;
    logic [8:0][1:0]  cells;
    logic             mover;  // 0 = X, 1 = O
    logic [1:0]       res;
    logic             ill;
    logic [3:0]       pend;   // cell number chosen by the last accepted key
    logic [31:0]      age;    // cycles already spent in OVER
  } mdl_t;

  mdl_t m;

  function automatic mdl_t fresh(mdl_t x);
    mdl_t n = x;
    n.cells = '0;
    n.mover = 1'b0;
    n.res   = 2'b00;
    n.age   = 0;
    return n;
  endfunction

  function automatic mdl_t mreset();
    mdl_t n = '0;
    return n;
  endfunction

  function automatic bit has_line(logic [8:0][1:0] c, logic [1:0] who);
    for (int r = 0; r < 3; r++)
      if (c[3*r] == who && c[3*r+1] == who && c[3*r+2] == who) return 1'b1;
    for (int k = 0; k < 3; k++)
      if (c[k] == who && c[k+3] == who && c[k+6] == who) return 1'b1;
    if (c[0] == who && c[4] == who && c[8] == who) return 1'b1;
    if (c[2] == who && c[4] == who && c[6] == who) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit is_full(logic [8:0][1:0] c);
    for (int i = 0; i < 9; i++) if (c[i] == 2'd0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic mdl_t step(mdl_t x, logic en, logic kv, logic [3:0] kc);
    mdl_t n = x;
    logic [1:0] who;
    n.ill = 1'b0;
    who = x.mover ? 2'd2 : 2'd1;
    if (x.ph != 3'd0 && !en) begin
      n = fresh(n);
      n.ph = 3'd0;
    end else begin
      case (x.ph)
        3'd0: if (en) begin n = fresh(n); n.ph = 3'd1; end
        3'd1: begin
          if (kv && kc >= 4'd1 && kc <= 4'd9) begin
            n.pend = kc;
            n.ill  = (x.cells[kc - 4'd1] != 2'd0);
            n.ph   = 3'd2;
          end else if (kv && kc == 4'd10) begin
            n.cells = '0;
            n.mover = 1'b0;
          end
        end
        3'd2: begin
          if (x.cells[x.pend - 4'd1] != 2'd0) n.ph = 3'd1;
          else begin
            n.cells[x.pend - 4'd1] = who;
            n.ph = 3'd3;
          end
        end
        3'd3: begin
          if (has_line(x.cells, who)) begin
            n.res = x.mover ? 2'b10 : 2'b01; n.ph = 3'd4; n.age = 0;
          end else if (is_full(x.cells)) begin
            n.res = 2'b11; n.ph = 3'd4; n.age = 0;
          end else begin
            n.mover = ~x.mover; n.ph = 3'd1;
          end
        end
        3'd4: begin
          if (kv && x.age >= Hold - 1) begin n = fresh(n); n.ph = 3'd1; end
          else n.age = x.age + 1;
        end
        default: n.ph = 3'd0;
      endcase
    end
    return n;
  endfunction

  function automatic logic [17:0] pack_board(logic [8:0][1:0] c);
    logic [17:0] b = '0;
    for (int k = 1; k <= 9; k++) begin
      b[19 - 2*k] = (c[k-1] == 2'd2);
      b[18 - 2*k] = (c[k-1] == 2'd1);
    end
    return b;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= mreset();
    else     m <= step(m, game_en, key_valid, key_code);
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [25:0] got, exp;
    if (chk_en) begin
      got = {board, turn_o, result, in_main, illegal, state_o};
      exp = {pack_board(m.cells), m.mover, m.res, (m.ph == 3'd0), m.ill, m.ph};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL model t=%0t got={board %h turn %b res %b main %b ill %b st %0d} want={board %h turn %b res %b main %b ill %b st %0d}",
                 $time, board, turn_o, result, in_main, illegal, state_o,
                 exp[25:8], exp[7], exp[6:5], exp[4], exp[3], exp[2:0]);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  // One accepted move: key, then let PLACE and CHECK complete.
  task automatic play(logic [3:0] code);
    press(code);
    idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; game_en = 1'b1; key_valid = 1'b0; key_code = 4'd0;
    idle(2);
    check("reset board",   32'(board),   32'h0);
    check("reset state",   32'(state_o), 32'd0);
    check("reset in_main", 32'(in_main), 32'd1);
    chk_en = 1'b1;
    rst = 1'b0;
    idle(1);
    check("enter wait", 32'(state_o), 32'd1);

    // 1: X wins on the top row; latency of the last move.
    play(4'd1); play(4'd4); play(4'd2); play(4'd5);
    press(4'd3);
    check("win n+1 board", 32'(board), 32'h14A00);
    idle(1);
    check("win n+2 board",  32'(board),  32'h15A00);
    check("win n+2 result", 32'(result), 32'd0);
    idle(1);
    check("win result", 32'(result),  32'd1);
    check("win state",  32'(state_o), 32'd4);
    check("win turn",   32'(turn_o),  32'd0);

    // 4: early key in OVER dropped, later key restarts.
    press(4'd6);
    check("over early state", 32'(state_o), 32'd4);
    check("over early board", 32'(board),   32'h15A00);
    idle(Hold + 2);
    press(4'd7);
    check("over restart state",  32'(state_o), 32'd1);
    check("over restart board",  32'(board),   32'h0);
    check("over restart result", 32'(result),  32'd0);

    // 2: occupied cell.
    play(4'd5);
    press(4'd5);
    check("illegal pulse", 32'(illegal), 32'd1);
    idle(1);
    check("illegal drop",  32'(illegal), 32'd0);
    check("illegal turn",  32'(turn_o),  32'd1);
    check("illegal board", 32'(board),   32'h00100);
    press(4'd12); idle(1); press(4'd0); idle(1);
    check("ignored codes", 32'(board), 32'h00100);

    // 3: draw on a full board.
    press(4'd10);
    check("star board", 32'(board),  32'h0);
    check("star turn",  32'(turn_o), 32'd0);
    play(4'd1); play(4'd2); play(4'd3); play(4'd5); play(4'd4);
    play(4'd6); play(4'd8); play(4'd7); play(4'd9);
    check("draw result", 32'(result),  32'd3);
    check("draw board",  32'(board),   32'h196A5);
    check("draw state",  32'(state_o), 32'd4);
    idle(Hold + 2);
    press(4'd0);
    check("any code restart", 32'(state_o), 32'd1);

    // 5: leaving the game beats a simultaneous key.
    play(4'd1); play(4'd2);
    game_en = 1'b0;
    press(4'd3);
    check("leave state", 32'(state_o), 32'd0);
    check("leave main",  32'(in_main), 32'd1);
    check("leave board", 32'(board),   32'h0);
    press(4'd4);
    check("main keys ignored", 32'(board), 32'h0);
    game_en = 1'b1;
    idle(1);
    check("reenter wait", 32'(state_o), 32'd1);
    play(4'd4);
    check("cell4 X", 32'(board), 32'h00400);
    press(4'd10);
    check("star clears", 32'(board), 32'h0);

    // 6: reset during CHECK.
    play(4'd1);
    press(4'd2);
    check("in place", 32'(state_o), 32'd2);
    @(posedge clk); #1;
    check("in check", 32'(state_o), 32'd3);
    rst = 1'b1; game_en = 1'b0;
    #1;
    check("async rst board", 32'(board),   32'h0);
    check("async rst state", 32'(state_o), 32'd0);
    check("async rst main",  32'(in_main), 32'd1);
    check("async rst turn",  32'(turn_o),  32'd0);
    idle(2);
    rst = 1'b0;
    press(4'd5);
    check("post rst ignored", 32'(state_o), 32'd0);
    game_en = 1'b1;
    idle(1);
    check("post rst wait", 32'(state_o), 32'd1);
    play(4'd5);
    check("post rst move", 32'(board), 32'h00100);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
